// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA display path.
//   - Default 800x600@60 SVGA timing (SVGA_H_*/SVGA_V_*) and derived totals.
//   - Coordinate widths X_W/Y_W, also used by the framebuffer.
//   - rgb_t: 12-bit pixel layout {R[11:8], G[7:4], B[3:0]}.
//   - phase_e / phase_of(): decode of a scan counter into ACTIVE/FP/SYNC/BP.
package vga_pkg;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  localparam int SVGA_H_TOTAL = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
  localparam int SVGA_V_TOTAL = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int RGB_W = 12;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_e;

  // Phase boundaries are elaboration constants, so the sums fold away and
  // only comparators remain in hardware.
  function automatic phase_e phase_of(input logic [15:0] cnt, input int act,
                                      input int fp, input int sync);
    phase_e ph;
    if (cnt < 16'(act))                 ph = PH_ACTIVE;
    else if (cnt < 16'(act + fp))       ph = PH_FP;
    else if (cnt < 16'(act + fp + sync)) ph = PH_SYNC;
    else                                ph = PH_BP;
    return ph;
  endfunction

endpackage

// File: rtl/vga_pix_prescaler.sv
// vga_pix_prescaler: pixel-rate tick generator.
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   o_pix_tick out  high on the clk where the counter sits at CLK_DIV-1
// With CLK_DIV=1 the counter never leaves 0, so the tick is constant high.
module vga_pix_prescaler #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic o_pix_tick
);

  localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                   r_cnt <= r_cnt + 4'd1;
  end

  assign o_pix_tick = (r_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: display scan engine.
//   clk, rst            clock, asynchronous active-low reset
//   colour_in[11:0]     framebuffer pixel for the current x/y (same cycle)
//   x[10:0], y[9:0]     framebuffer read address, 0 outside the visible area
//   frame_trig          one-clk pulse when the scan enters vertical blanking
//   active              registered visible flag, aligned with RGB
//   hsync, vsync        registered syncs, SYNC_POL active
//   vga_r/g/b[3:0]      registered colour, zero during blanking
// Counters advance on the pixel tick; RGB, syncs and active all come from a
// single register stage so they leave the block mutually aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit SYNC_POL = 1'b1,
  parameter int CLK_DIV  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] colour_in,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             frame_trig,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic           w_pix_tick;
  logic [X_W-1:0] r_h_cnt;
  logic [Y_W-1:0] r_v_cnt;
  logic           w_h_last;
  logic           w_v_last;
  phase_e         w_h_phase;
  phase_e         w_v_phase;
  logic           w_visible;

  rgb_t           r_rgb;
  logic           r_active;
  logic           r_hsync;
  logic           r_vsync;

  vga_pix_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk        (clk),
    .rst        (rst),
    .o_pix_tick (w_pix_tick)
  );

  assign w_h_last = (r_h_cnt == X_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == Y_W'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign w_h_phase = phase_of(16'(r_h_cnt), H_ACTIVE, H_FP, H_SYNC);
  assign w_v_phase = phase_of(16'(r_v_cnt), V_ACTIVE, V_FP, V_SYNC);
  assign w_visible = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

  // Address is clamped to 0 in blanking so the framebuffer index stays in range.
  assign x = (w_h_phase == PH_ACTIVE) ? r_h_cnt : '0;
  assign y = (w_v_phase == PH_ACTIVE) ? r_v_cnt : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb    <= '0;
      r_active <= 1'b0;
      r_hsync  <= ~SYNC_POL;
      r_vsync  <= ~SYNC_POL;
    end else if (w_pix_tick) begin
      r_rgb    <= w_visible ? rgb_t'(colour_in) : '0;
      r_active <= w_visible;
      r_hsync  <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      r_vsync  <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Qualified by the tick so the pulse is one clk wide even when the counters
  // dwell on (0, V_ACTIVE) for CLK_DIV clks.
  assign frame_trig = w_pix_tick && (r_h_cnt == '0) && (r_v_cnt == Y_W'(V_ACTIVE));

  assign active = r_active;
  assign hsync  = r_hsync;
  assign vsync  = r_vsync;
  assign vga_r  = r_rgb.r;
  assign vga_g  = r_rgb.g;
  assign vga_b  = r_rgb.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: two instances share clk/rst.
//   d1: full 800-pixel SVGA line, short 11-line frame, CLK_DIV=1, SYNC_POL=1.
//   d4: 31-pixel line, 11-line frame, CLK_DIV=4, SYNC_POL=0.
// The model derives every output from k, the number of clk edges since reset
// release: k/D pixel ticks have elapsed, the counters hold pixel k/D and the
// registered outputs describe pixel k/D-1.
module tb_vga_timing_gen;

  typedef struct {
    int x; int y; int rgb;
    bit act; bit hs; bit vs; bit trig;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] c1, c4;
  logic [10:0] x1, x4;
  logic [9:0]  y1, y4;
  logic        tr1, tr4, act1, act4, hs1, hs4, vs1, vs4;
  logic [3:0]  r1, g1, b1, r4, g4, b4;

  assign c1 = {x1[3:0], y1[3:0], 4'hA};
  assign c4 = {x4[3:0], y4[3:0], 4'hA};

  vga_timing_gen #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .SYNC_POL(1'b1), .CLK_DIV(1)) d1 (
    .clk(clk), .rst(rst), .colour_in(c1), .x(x1), .y(y1), .frame_trig(tr1),
    .active(act1), .hsync(hs1), .vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .SYNC_POL(1'b0), .CLK_DIV(4)) d4 (
    .clk(clk), .rst(rst), .colour_in(c4), .x(x4), .y(y4), .frame_trig(tr4),
    .active(act4), .hsync(hs4), .vsync(vs4), .vga_r(r4), .vga_g(g4), .vga_b(b4));

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  always @(posedge clk or negedge rst)
    if (!rst) k <= 0;
    else      k <= k + 1;

  function automatic exp_t model(int kk, int D, bit pol, int ha, int hf, int hs,
                                 int hb, int va, int vf, int vs);
    exp_t e;
    int ht, fr, n, p, h, v, q, qh, qv;
    bit vis;
    ht = ha + hf + hs + hb;
    fr = ht * (va + vf + vs + vb_dummy(vs, vb_total(va, vf, vs)));
    n  = kk / D;
    p  = n % fr;
    h  = p % ht;
    v  = p / ht;
    e.x    = (h < ha) ? h : 0;
    e.y    = (v < va) ? v : 0;
    e.trig = ((kk % D) == D - 1) && (h == 0) && (v == va);
    if (n == 0) begin
      e.rgb = 0; e.act = 1'b0; e.hs = ~pol; e.vs = ~pol;
    end else begin
      q   = (n - 1) % fr;
      qh  = q % ht;
      qv  = q / ht;
      vis = (qh < ha) && (qv < va);
      e.act = vis;
      e.rgb = vis ? (((qh % 16) << 8) | ((qv % 16) << 4) | 10) : 0;
      e.hs  = ((qh >= ha + hf) && (qh < ha + hf + hs)) ? pol : ~pol;
      e.vs  = ((qv >= va + vf) && (qv < va + vf + vs)) ? pol : ~pol;
    end
    return e;
  endfunction

  // Both instances use a 2-line vertical back porch.
  function automatic int vb_total(int va, int vf, int vs);
    return 2 + 0 * (va + vf + vs);
  endfunction
  function automatic int vb_dummy(int vs, int vb);
    return vb + 0 * vs;
  endfunction

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic cmp(string nm, exp_t e, int ax, int ay, int argb, bit aa,
                     bit ah, bit av, bit at);
    vectors++;
    if (ax != e.x || ay != e.y || argb != e.rgb || aa != e.act ||
        ah != e.hs || av != e.vs || at != e.trig) begin
      miscompares++;
      $display("FAIL %s k=%0d got x=%0d y=%0d rgb=%03h act=%0b hs=%0b vs=%0b trig=%0b want x=%0d y=%0d rgb=%03h act=%0b hs=%0b vs=%0b trig=%0b",
               nm, k, ax, ay, argb, aa, ah, av, at,
               e.x, e.y, e.rgb, e.act, e.hs, e.vs, e.trig);
      if (miscompares >= 50) finish_run();
    end
  endtask

  task automatic chk(string nm, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
      if (miscompares >= 50) finish_run();
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    cmp("d1", model(k, 1, 1'b1, 800, 40, 128, 88, 6, 1, 2),
        int'(x1), int'(y1), int'({r1, g1, b1}), act1, hs1, vs1, tr1);
    cmp("d4", model(k, 4, 1'b0, 16, 4, 6, 5, 6, 1, 2),
        int'(x4), int'(y4), int'({r4, g4, b4}), act4, hs4, vs4, tr4);
  end

  // Event recorder for the hand-computed timing literals.
  bit rec = 1'b0;
  int h1_rise[$], v1_rise[$], t1[$], h4_fall[$], t4[$];
  int h1_w = 0, act1_w = 0, v1_w = 0;
  logic p_hs1 = 1'b0, p_vs1 = 1'b0, p_hs4 = 1'b1;

  always @(negedge clk) begin
    p_hs1 <= hs1;
    p_vs1 <= vs1;
    p_hs4 <= hs4;
    if (rec && rst) begin
      if (hs1 && !p_hs1) h1_rise.push_back(k);
      if (vs1 && !p_vs1) v1_rise.push_back(k);
      if (!hs4 && p_hs4) h4_fall.push_back(k);
      if (tr1) t1.push_back(k);
      if (tr4) t4.push_back(k);
      if (k >= 1 && k <= 1056 && hs1)  h1_w   <= h1_w + 1;
      if (k >= 1 && k <= 1056 && act1) act1_w <= act1_w + 1;
      if (k >= 1 && k <= 11616 && vs1) v1_w   <= v1_w + 1;
    end
  end

  task automatic wait_k(int n);
    int g = 0;
    while (k < n && g < 60000) begin
      @(negedge clk);
      g++;
    end
    if (k < n) begin
      chk("wait_k_timeout", k, n);
      finish_run();
    end
  endtask

  function automatic int q_at(int q[$], int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_hsync1", int'(hs1), 0);
    chk("rst_vsync1", int'(vs1), 0);
    chk("rst_hsync4", int'(hs4), 1);
    chk("rst_rgb1", int'({r1, g1, b1}), 0);
    chk("rst_active1", int'(act1), 0);
    chk("rst_x1", int'(x1), 0);

    rec = 1'b1;
    rst = 1'b1;
    wait_k(1); chk("x1_k1", int'(x1), 1);
    wait_k(2); chk("x1_k2", int'(x1), 2);
    wait_k(3); chk("x1_k3", int'(x1), 3); chk("x4_k3", int'(x4), 0);
    wait_k(4); chk("x4_k4", int'(x4), 1);
    wait_k(900); chk("x1_hblank", int'(x1), 0);
    wait_k(3174);
    chk("rgb1_5_3", int'({r1, g1, b1}), 12'h53A);
    chk("act1_5_3", int'(act1), 1);
    wait_k(24000);
    rec = 1'b0;

    chk("h1_rise0", q_at(h1_rise, 0), 841);
    chk("h1_rise1", q_at(h1_rise, 1), 1897);
    chk("h1_width", h1_w, 128);
    chk("act1_line", act1_w, 800);
    chk("v1_rise0", q_at(v1_rise, 0), 7393);
    chk("v1_width", v1_w, 2112);
    chk("t1_first", q_at(t1, 0), 6336);
    chk("t1_second", q_at(t1, 1), 17952);
    chk("h4_fall0", q_at(h4_fall, 0), 84);
    chk("t4_first", q_at(t4, 0), 747);
    chk("t4_second", q_at(t4, 1), 2111);

    // Mid-frame reset with the scan at (700, last active line).
    wait_k(29212);
    chk("pre_rst_x1", int'(x1), 700);
    chk("pre_rst_y1", int'(y1), 5);
    #2 rst = 1'b0;
    #1;
    chk("async_x1", int'(x1), 0);
    chk("async_y1", int'(y1), 0);
    chk("async_rgb1", int'({r1, g1, b1}), 0);
    chk("async_hs4", int'(hs4), 1);
    t1.delete();
    rec = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_k(12000);
    chk("t1_after_rst", q_at(t1, 0), 6336);
    finish_run();
  end

endmodule
